// File: rtl/sum_accumulator_if.sv
// Stream bundle between the ripple adder and the burst accumulator.
// Input side carries adder beats; output side carries the burst total.
interface sum_accumulator_if #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sum;
    logic             in_cout;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    // Producer of beats and consumer of totals
    modport master (
        output in_valid, in_sum, in_cout, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    // The accumulator itself
    modport slave (
        input  in_valid, in_sum, in_cout, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/sum_accumulator.sv
// Burst accumulator behind the 4-bit ripple adder: sums COUNT_N beats of
// {cout, sum} into a registered total with a sticky overflow flag and
// hands it downstream on a valid/ready port.
module sum_accumulator #(
    parameter int IN_W    = 4,
    parameter int ACC_W   = 6,
    parameter int COUNT_N = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    sum_accumulator_if.slave    bus,
    input  logic                clear,
    output logic                busy
);
    localparam int BEAT_W = IN_W + 1;
    localparam int CNT_W  = $clog2(COUNT_N + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state, state_nx;
    logic [ACC_W-1:0]   acc, acc_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               ovf, ovf_nx;

    logic [BEAT_W-1:0]  beat;
    logic [ACC_W-1:0]   v;
    logic               accept;
    logic [CNT_W-1:0]   cnt_inc;
    logic [ACC_W:0]     sum_c;

    // Modulo-2^ACC_W addition; the extra top bit is the carry out of ACC_W-1.
    function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Handshake and output decode; clear blocks acceptance combinationally.
    always_comb begin
        beat          = {bus.in_cout, bus.in_sum};
        v             = ACC_W'(beat);
        bus.in_ready  = !clear && (state != HOLD);
        accept        = bus.in_valid && bus.in_ready;
        bus.out_valid = (state == HOLD);
        bus.out_acc   = acc;
        bus.out_ovf   = ovf;
        busy          = (state != IDLE);
    end

    // Next-state and datapath update for the IDLE/ACCUM/HOLD sequencer.
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        ovf_nx   = ovf;
        cnt_inc  = cnt + CNT_W'(1);
        sum_c    = add_carry(acc, v);
        if (clear) begin
            state_nx = IDLE;
            acc_nx   = '0;
            cnt_nx   = '0;
            ovf_nx   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        acc_nx   = v;
                        ovf_nx   = 1'b0;
                        cnt_nx   = CNT_W'(1);
                        state_nx = (COUNT_N == 1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_nx = sum_c[ACC_W-1:0];
                        ovf_nx = ovf | sum_c[ACC_W];
                        cnt_nx = cnt_inc;
                        if (cnt_inc == CNT_W'(COUNT_N)) begin
                            state_nx = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // acc/ovf stay put until the next burst's first beat
                    if (bus.out_ready) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // State and accumulator registers; reset discards any partial burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            ovf   <= ovf_nx;
        end
    end
endmodule
